execute_muldiv: RTL

Parametrised successor to the single-cycle execute stage. Adds an iterative multiply/divide unit (MUL, DIV, DIVU, REM, REMU, plus 32-bit W variants) behind the same stall handshake: stall in from memory, stall out to decode. Non-muldiv ops pass through in one cycle. Sits between the decode register and the memory stage, and drives a registered result, destination and pc downstream.

---
 rtl/execute_muldiv.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_muldiv.sv
// execute_muldiv: execute stage with an iterative multiply/divide unit.
// PASS-class ops retire in one cycle; MUL/DIV/DIVU/REM/REMU (and their W forms)
// iterate BITS_PER_CYCLE bits per cycle and hold decode via stall_out.
// Optional build macro: MULDIV_EARLY_OUT_EN lets trivially resolved muldiv ops
// (divide by zero, signed overflow, MUL by 0 or 1) skip the iteration loop.
module execute_muldiv #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned DST_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_srca,
  input  logic [XLEN-1:0]  in_srcb,
  input  logic [DST_W-1:0] in_dst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  input  logic             stall_in,
  output logic             stall_out,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [DST_W-1:0] out_dst,
  output logic [XLEN-1:0]  out_pc
);

  localparam int unsigned CntW = $clog2(XLEN / BITS_PER_CYCLE);
  // W variants only exist on a 64-bit datapath.
  localparam bit WordEn = (XLEN > 32);
  localparam logic [CntW-1:0] CntFull = CntW'(XLEN / BITS_PER_CYCLE - 1);
  localparam logic [CntW-1:0] CntWord = CntW'(32 / BITS_PER_CYCLE - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpPass = 3'd0;
  localparam logic [2:0] OpMul  = 3'd1;
  localparam logic [2:0] OpDiv  = 3'd2;
  localparam logic [2:0] OpDivu = 3'd3;
  localparam logic [2:0] OpRem  = 3'd4;
  localparam logic [2:0] OpRemu = 3'd5;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v[31:0];
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [2:0]       op_q;
  logic             word_q;
  logic             neg_q;
  // x_q: left-aligned multiplier / dividend, quotient bits shift in at bit 0.
  // y_q: multiplicand / divisor.  acc_q: product / partial remainder.
  logic [XLEN-1:0]  x_q, y_q, acc_q;
  logic [DST_W-1:0] dst_q;
  logic [XLEN-1:0]  pc_q;

  logic             in_muldiv, in_w, in_signed, in_is_mul, in_is_div;
  logic             sign_a, sign_b, b_zero;
  logic [31:0]      a32_abs, b32_abs;
  logic [XLEN-1:0]  a_abs, b_abs, x_src, x_init, y_init;
  logic             neg_init;
  logic             start;
  logic             early;

  logic [XLEN-1:0]  x_step, acc_step;
  logic [XLEN:0]    rem_t;
  logic [XLEN-1:0]  raw_res, fixed_res, done_res;

  // Decode the live decode-slot instruction into absolute operands and sign flags.
  always_comb begin
    in_muldiv = (in_op >= OpMul) && (in_op <= OpRemu);
    in_is_mul = (in_op == OpMul);
    in_is_div = (in_op == OpDiv) || (in_op == OpDivu);
    in_signed = (in_op == OpMul) || (in_op == OpDiv) || (in_op == OpRem);
    in_w      = WordEn && in_word;
    sign_a    = in_signed && (in_w ? in_srca[31] : in_srca[XLEN-1]);
    sign_b    = in_signed && (in_w ? in_srcb[31] : in_srcb[XLEN-1]);
    b_zero    = in_w ? (in_srcb[31:0] == 32'd0) : (in_srcb == '0);
    a32_abs   = sign_a ? (32'd0 - in_srca[31:0]) : in_srca[31:0];
    b32_abs   = sign_b ? (32'd0 - in_srcb[31:0]) : in_srcb[31:0];
    a_abs     = in_w ? XLEN'(a32_abs) : (sign_a ? ('0 - in_srca) : in_srca);
    b_abs     = in_w ? XLEN'(b32_abs) : (sign_b ? ('0 - in_srcb) : in_srcb);
    x_src     = in_is_mul ? b_abs : a_abs;
    x_init    = in_w ? (x_src << (XLEN - 32)) : x_src;
    y_init    = in_is_mul ? a_abs : b_abs;
    // Divide by zero keeps an all-ones quotient regardless of operand signs.
    if (in_is_mul) begin
      neg_init = sign_a ^ sign_b;
    end else if (in_is_div) begin
      neg_init = (sign_a ^ sign_b) && !b_zero;
    end else begin
      neg_init = sign_a;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic            a_min, b_ones, b_one;
  logic [XLEN-1:0] a_ext, early_res, early_res_q;
  logic            early_q;

  // Recognise ops whose result is known without iterating.
  always_comb begin
    a_ext     = in_w ? sext32(in_srca) : in_srca;
    a_min     = in_w ? (in_srca[31:0] == 32'h8000_0000) : (in_srca == {1'b1, {(XLEN-1){1'b0}}});
    b_ones    = in_w ? (&in_srcb[31:0]) : (&in_srcb);
    b_one     = in_w ? (in_srcb[31:0] == 32'd1) : (in_srcb == XLEN'(1));
    early     = 1'b0;
    early_res = '0;
    if (in_is_mul) begin
      if (b_zero) begin
        early     = 1'b1;
        early_res = '0;
      end else if (b_one) begin
        early     = 1'b1;
        early_res = a_ext;
      end
    end else if (b_zero) begin
      early     = 1'b1;
      early_res = in_is_div ? '1 : a_ext;
    end else if (in_signed && a_min && b_ones) begin
      early     = 1'b1;
      early_res = in_is_div ? a_ext : '0;
    end
  end
`else
  assign early = 1'b0;
`endif

  assign start     = (state_q == StIdle) && in_valid && in_muldiv && !flush;
  assign stall_out = in_valid && in_muldiv && (state_q != StDone) && !flush;

  // Next FSM state; flush overrides everything but reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid && in_muldiv) state_d = early ? StDone : StBusy;
      StBusy: if (cnt_q == '0) state_d = StDone;
      StDone: if (!stall_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // One iteration: BITS_PER_CYCLE shift-add or restoring-subtract steps, MSB first.
  always_comb begin
    x_step   = x_q;
    acc_step = acc_q;
    rem_t    = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q == OpMul) begin
        acc_step = (acc_step << 1) + (x_step[XLEN-1] ? y_q : '0);
        x_step   = x_step << 1;
      end else begin
        rem_t  = {acc_step, x_step[XLEN-1]};
        x_step = x_step << 1;
        if (rem_t >= {1'b0, y_q}) begin
          rem_t     = rem_t - {1'b0, y_q};
          x_step[0] = 1'b1;
        end
        acc_step = rem_t[XLEN-1:0];
      end
    end
  end

  // Sign correction and W sign extension of the finished result.
  always_comb begin
    raw_res   = ((op_q == OpDiv) || (op_q == OpDivu)) ? x_q : acc_q;
    fixed_res = neg_q ? ('0 - raw_res) : raw_res;
    done_res  = word_q ? sext32(fixed_res) : fixed_res;
`ifdef MULDIV_EARLY_OUT_EN
    if (early_q) done_res = early_res_q;
`endif
  end

  // FSM state, operand capture and iteration registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpPass;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      dst_q   <= '0;
      pc_q    <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      early_q     <= 1'b0;
      early_res_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q  <= in_w ? CntWord : CntFull;
        op_q   <= in_op;
        word_q <= in_w;
        neg_q  <= neg_init;
        x_q    <= x_init;
        y_q    <= y_init;
        acc_q  <= '0;
        dst_q  <= in_dst;
        pc_q   <= in_pc;
`ifdef MULDIV_EARLY_OUT_EN
        early_q     <= early;
        early_res_q <= early_res;
`endif
      end else if ((state_q == StBusy) && !flush) begin
        x_q   <= x_step;
        acc_q <= acc_step;
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Output slot: stall holds, DONE or PASS loads, anything else is a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dst    <= '0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall_in) begin
      if (state_q == StDone) begin
        out_valid  <= 1'b1;
        out_result <= done_res;
        out_dst    <= dst_q;
        out_pc     <= pc_q;
      end else if ((state_q == StIdle) && in_valid && !in_muldiv) begin
        out_valid  <= 1'b1;
        out_result <= in_srca;
        out_dst    <= in_dst;
        out_pc     <= in_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
